// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, mul/div FSM states, forward selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_pkg;

  // aluCtrl encoding
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_MUL  = 3'd5;
  localparam logic [2:0] ALU_DIVU = 3'd6;
  localparam logic [2:0] ALU_REMU = 3'd7;

  // Iterative mul/div sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  // Operand source after forwarding
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  // True for the multi-cycle opcodes (5, 6, 7)
  function automatic logic is_muldiv(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (low half) / restoring divide, one bit per cycle.
// Latency: accept cycle + WIDTH BUSY cycles + 1 DONE cycle; result valid during DONE.
// Backpressure: stall is high in the accept cycle and throughout BUSY; inputs ignored outside IDLE.
import exec_pkg::*;

module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  // a: multiplicand (mul) or dividend-shifting-into-quotient (div)
  logic [WIDTH-1:0] a_q, a_d;
  // b: multiplier (mul) or divisor (div)
  logic [WIDTH-1:0] b_q, b_d;
  // acc: product (mul) or partial remainder (div)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   rem_sh;

  // Next-state: latch operands on start, then one shift-add or restoring step per BUSY cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_sh  = {acc_q, a_q[WIDTH-1]};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          op_d    = op;
          a_d     = op_a;
          b_d     = op_b;
          acc_d   = '0;
        end
      end
      S_BUSY: begin
        if (op_q == ALU_MUL) begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end else if (rem_sh >= {1'b0, b_q}) begin
          // A zero divisor always subtracts, giving all-ones quotient and remainder = dividend
          acc_d = rem_sh[WIDTH-1:0] - b_q;
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Stall must cover the accept cycle, so it looks at start while IDLE; forced low in reset
  assign stall  = !rst && (((state_q == S_IDLE) && start) || (state_q == S_BUSY));
  assign done   = (state_q == S_DONE);
  assign result = (op_q == ALU_DIVU) ? a_q : acc_q;

endmodule

// File: rtl/exec_muldiv.sv
// Execute stage: forwarding, ALU, branch adder, EX/MEM register, plus iterative mul/div.
// Latency: single-cycle ops 1 cycle; mul/div WIDTH+2 cycles from acceptance to EX/MEM.
// Backpressure: stall holds PC/IF-ID/ID-EX while mul/div runs; EX/MEM takes bubbles meanwhile.
import exec_pkg::*;

module exec_muldiv #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_IDEX,
  input  logic [WIDTH-1:0]    readData1,
  input  logic [WIDTH-1:0]    readData2,
  input  logic [WIDTH-1:0]    address,
  input  logic [WIDTH-1:0]    pcIncr,
  input  logic                ctrlAluSrc,
  input  logic [2:0]          aluCtrl,
  input  logic                branch,
  input  logic                regWrite_IDEX,
  input  logic [REG_BITS-1:0] rs_IDEX,
  input  logic [REG_BITS-1:0] rt_IDEX,
  input  logic [REG_BITS-1:0] rd_IDEX,
  input  logic [REG_BITS-1:0] rd_MEMWB,
  input  logic                regWrite_MEMWB,
  input  logic [WIDTH-1:0]    valueToWB,
  output logic [WIDTH-1:0]    result_EXMEM,
  output logic [REG_BITS-1:0] rd_EXMEM,
  output logic                regWrite_EXMEM,
  output logic                valid_EXMEM,
  output logic [WIDTH-1:0]    resultBranch,
  output logic                pcSrc,
  output logic                flushPrevInstr,
  output logic                stall
);

  fwd_sel_e            fwd_a, fwd_b;
  logic [WIDTH-1:0]    src_a, src_b, op2, alu_res, md_result;
  logic                zero, md_start, md_done;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic                regwrite_q, regwrite_d;
  logic                valid_q, valid_d;
  logic                exmem_fwd_ok;

  assign exmem_fwd_ok = regwrite_q && valid_q && (rd_q != '0);

  // Forward select: own EX/MEM beats MEM/WB beats register file
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (exmem_fwd_ok && (rd_q == rs_IDEX))
      fwd_a = FWD_MEM;
    else if (regWrite_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rs_IDEX))
      fwd_a = FWD_WB;
    if (exmem_fwd_ok && (rd_q == rt_IDEX))
      fwd_b = FWD_MEM;
    else if (regWrite_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rt_IDEX))
      fwd_b = FWD_WB;
  end

  // Operand muxes; the immediate bypasses forwarding entirely
  always_comb begin
    case (fwd_a)
      FWD_MEM: src_a = result_q;
      FWD_WB:  src_a = valueToWB;
      default: src_a = readData1;
    endcase
    case (fwd_b)
      FWD_MEM: src_b = result_q;
      FWD_WB:  src_b = valueToWB;
      default: src_b = readData2;
    endcase
    op2 = ctrlAluSrc ? address : src_b;
  end

  assign md_start = valid_IDEX && is_muldiv(aluCtrl);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (reset),
    .start  (md_start),
    .op     (aluCtrl),
    .op_a   (src_a),
    .op_b   (src_b),
    .stall  (stall),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle ALU; multi-cycle opcodes take the iterative unit's result
  always_comb begin
    alu_res = '0;
    case (aluCtrl)
      ALU_ADD: alu_res = src_a + op2;
      ALU_SUB: alu_res = src_a - op2;
      ALU_AND: alu_res = src_a & op2;
      ALU_OR:  alu_res = src_a | op2;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(op2))};
      default: alu_res = md_done ? md_result : '0;
    endcase
  end

  assign zero           = (alu_res == '0);
  assign pcSrc          = branch && zero && valid_IDEX && !stall;
  assign flushPrevInstr = pcSrc;
  assign resultBranch   = pcIncr + (address << 2);

  // EX/MEM next value: a bubble whenever the mul/div unit is stalling the pipe
  always_comb begin
    result_d   = alu_res;
    rd_d       = rd_IDEX;
    regwrite_d = regWrite_IDEX;
    valid_d    = valid_IDEX;
    if (stall) begin
      regwrite_d = 1'b0;
      valid_d    = 1'b0;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      result_q   <= result_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_d;
    end
  end

  assign result_EXMEM   = result_q;
  assign rd_EXMEM       = rd_q;
  assign regWrite_EXMEM = regwrite_q;
  assign valid_EXMEM    = valid_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv: forwarding, ALU ops, branch, mul/div latency, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_exec_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_IDEX;
  logic [31:0] readData1, readData2, address, pcIncr, valueToWB;
  logic        ctrlAluSrc, branch, regWrite_IDEX, regWrite_MEMWB;
  logic [2:0]  aluCtrl;
  logic [4:0]  rs_IDEX, rt_IDEX, rd_IDEX, rd_MEMWB;
  logic [31:0] result_EXMEM, resultBranch;
  logic [4:0]  rd_EXMEM;
  logic        regWrite_EXMEM, valid_EXMEM, pcSrc, flushPrevInstr, stall;

  int n_chk  = 0;
  int n_pass = 0;

  exec_muldiv #(.WIDTH(32), .REG_BITS(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_IDEX     (valid_IDEX),
    .readData1      (readData1),
    .readData2      (readData2),
    .address        (address),
    .pcIncr         (pcIncr),
    .ctrlAluSrc     (ctrlAluSrc),
    .aluCtrl        (aluCtrl),
    .branch         (branch),
    .regWrite_IDEX  (regWrite_IDEX),
    .rs_IDEX        (rs_IDEX),
    .rt_IDEX        (rt_IDEX),
    .rd_IDEX        (rd_IDEX),
    .rd_MEMWB       (rd_MEMWB),
    .regWrite_MEMWB (regWrite_MEMWB),
    .valueToWB      (valueToWB),
    .result_EXMEM   (result_EXMEM),
    .rd_EXMEM       (rd_EXMEM),
    .regWrite_EXMEM (regWrite_EXMEM),
    .valid_EXMEM    (valid_EXMEM),
    .resultBranch   (resultBranch),
    .pcSrc          (pcSrc),
    .flushPrevInstr (flushPrevInstr),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic src, input logic rw, input logic br);
    valid_IDEX    = v;
    aluCtrl       = op;
    rs_IDEX       = rs;
    rt_IDEX       = rt;
    rd_IDEX       = rd;
    readData1     = d1;
    readData2     = d2;
    address       = imm;
    ctrlAluSrc    = src;
    regWrite_IDEX = rw;
    branch        = br;
  endtask

  // Issue a mul/div (rs=12, rt=13, rd=14) and measure stall length, bubbles and latency
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int stalls, bubbles, lat;
    bit seen;
    stalls = 0; bubbles = 0; lat = 0; seen = 0;
    drive(1'b1, op, 5'd12, 5'd13, 5'd14, a, b, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (stall) stalls++;
      tick();
      if (valid_EXMEM) begin
        seen = 1;
        lat  = k;
      end else begin
        bubbles++;
      end
    end
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_seen"},    32'(seen),    32'd1);
    chk({tag, "_latency"}, 32'(lat),     32'd34);
    chk({tag, "_stalls"},  32'(stalls),  32'd33);
    chk({tag, "_bubbles"}, 32'(bubbles), 32'd33);
    chk({tag, "_result"},  result_EXMEM, exp);
    chk({tag, "_rd"},      32'(rd_EXMEM), 32'd14);
  endtask

  initial begin
    reset          = 1'b1;
    pcIncr         = 32'h100;
    rd_MEMWB       = 5'd0;
    regWrite_MEMWB = 1'b0;
    valueToWB      = 32'd0;
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_result",   result_EXMEM,          32'd0);
    chk("rst_rd",       32'(rd_EXMEM),         32'd0);
    chk("rst_regwrite", 32'(regWrite_EXMEM),   32'd0);
    chk("rst_valid",    32'(valid_EXMEM),      32'd0);
    chk("rst_stall",    32'(stall),            32'd0);
    @(negedge clk);
    reset = 1'b0;

    // add 5+7 -> rd3
    drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("add_stall", 32'(stall), 32'd0);
    tick();
    chk("add_result",   result_EXMEM,        32'd12);
    chk("add_rd",       32'(rd_EXMEM),       32'd3);
    chk("add_valid",    32'(valid_EXMEM),    32'd1);
    chk("add_regwrite", 32'(regWrite_EXMEM), 32'd1);

    // sub rs=3 forwards 12 from EX/MEM: 12-3 = 9 -> rd5
    drive(1'b1, 3'd1, 5'd3, 5'd4, 5'd5, 32'd0, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("sub_fwd_mem", result_EXMEM, 32'd9);

    // EX/MEM (9) beats MEM/WB (4) on rs=5: 9+1 -> rd7
    rd_MEMWB = 5'd5; regWrite_MEMWB = 1'b1; valueToWB = 32'd4;
    drive(1'b1, 3'd0, 5'd5, 5'd6, 5'd7, 32'd100, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("fwd_priority", result_EXMEM, 32'd10);

    // Only MEM/WB matches now: 4+1 -> rd8
    drive(1'b1, 3'd0, 5'd5, 5'd6, 5'd8, 32'd100, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("fwd_wb", result_EXMEM, 32'd5);

    // Write to r0: 20+0
    drive(1'b1, 3'd0, 5'd9, 5'd10, 5'd0, 32'd20, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("rd0_write", result_EXMEM, 32'd20);

    // rs=0 with rd=0 on both forwarding sources: register file used, 1+1
    rd_MEMWB = 5'd0;
    drive(1'b1, 3'd0, 5'd0, 5'd11, 5'd9, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("rd0_nofwd", result_EXMEM, 32'd2);
    regWrite_MEMWB = 1'b0;

    // Immediate path ignores readData2: 10 + 0x20
    drive(1'b1, 3'd0, 5'd16, 5'd17, 5'd18, 32'd10, 32'd999, 32'h20, 1'b1, 1'b1, 1'b0);
    tick();
    chk("add_imm", result_EXMEM, 32'h2A);

    drive(1'b1, 3'd2, 5'd16, 5'd17, 5'd18, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("and", result_EXMEM, 32'hF000);

    drive(1'b1, 3'd3, 5'd16, 5'd17, 5'd18, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("or", result_EXMEM, 32'hFFF0);

    drive(1'b1, 3'd4, 5'd16, 5'd17, 5'd18, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("slt_signed", result_EXMEM, 32'd1);

    // Taken branch: 8-8 == 0, target 0x100 + 3*4
    drive(1'b1, 3'd1, 5'd20, 5'd21, 5'd0, 32'd8, 32'd8, 32'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("br_pcsrc",  32'(pcSrc),          32'd1);
    chk("br_flush",  32'(flushPrevInstr), 32'd1);
    chk("br_target", resultBranch,        32'h10C);
    tick();
    drive(1'b1, 3'd1, 5'd20, 5'd21, 5'd0, 32'd8, 32'd9, 32'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("br_not_taken", 32'(pcSrc), 32'd0);
    tick();

    // Multi-cycle ops, each issued right after the previous result appears
    run_md("mul", 3'd5, 32'd7, 32'd6, 32'd42);
    // Dependent add forwards the product with no extra stall: 42+1 -> rd15
    drive(1'b1, 3'd0, 5'd14, 5'd0, 5'd15, 32'd0, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("dep_stall", 32'(stall), 32'd0);
    tick();
    chk("dep_result", result_EXMEM, 32'd43);
    run_md("divu",   3'd6, 32'd100, 32'd7, 32'd14);
    run_md("remu",   3'd7, 32'd100, 32'd7, 32'd2);
    run_md("divu0",  3'd6, 32'd5,   32'd0, 32'hFFFF_FFFF);
    run_md("remu0",  3'd7, 32'd5,   32'd0, 32'd5);

    // Reset in the middle of a mul abandons it
    drive(1'b1, 3'd5, 5'd12, 5'd13, 5'd14, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("arst_stall",    32'(stall),          32'd0);
    chk("arst_result",   result_EXMEM,        32'd0);
    chk("arst_valid",    32'(valid_EXMEM),    32'd0);
    chk("arst_regwrite", 32'(regWrite_EXMEM), 32'd0);
    chk("arst_rd",       32'(rd_EXMEM),       32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_add",   result_EXMEM,     32'd5);
    chk("post_rst_valid", 32'(valid_EXMEM), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
